motor_drive: RTL and testbench

Converts the 2-bit motor speed code from the tracking/u-turn controller into H-bridge PWM drive signals. It sits directly downstream of that controller and feeds the motor driver chip pins. The block ramps duty up smoothly, drops to zero immediately on stop, inserts a dead time on every forward/backward reversal, and changes duty only at PWM period boundaries so no pulse is ever truncated.

---
 rtl/motor_drive.sv | 134 +++++++++++++
 tb/tb_motor_drive.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/motor_drive.sv
// H-bridge PWM driver: turns a 2-bit speed code into ramped, period-aligned PWM on in1/in2,
// with an enforced dead time whenever the drive direction reverses.
module motor_drive #(
    parameter int PWM_PERIOD = 2500,
    parameter int DUTY_FOR   = 1500,
    parameter int DUTY_FAST  = 2250,
    parameter int DUTY_BACK  = 1500,
    parameter int RAMP_DIV   = 50000,
    parameter int RAMP_STEP  = 25,
    parameter int DEAD_TIME  = 5000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  motor,
    output logic        in1,
    output logic        in2,
    output logic        dir,
    output logic [11:0] duty,
    output logic        moving
);
    localparam int CW = $clog2(PWM_PERIOD + 1);
    localparam int PW = $clog2(RAMP_DIV + 1);
    localparam int DW = $clog2(DEAD_TIME + 1);

    localparam logic [CW-1:0] CNT_MAX   = CW'(PWM_PERIOD - 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(RAMP_DIV - 1);
    localparam logic [DW-1:0] DEAD_MAX  = DW'(DEAD_TIME - 1);
    localparam logic [11:0]   D_FOR     = 12'(DUTY_FOR);
    localparam logic [11:0]   D_FAST    = 12'(DUTY_FAST);
    localparam logic [11:0]   D_BACK    = 12'(DUTY_BACK);
    localparam logic [11:0]   D_STEP    = 12'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t        state, state_n;
    logic [1:0]    motor_q;
    logic [CW-1:0] cnt, cnt_n;
    logic [PW-1:0] presc;
    logic [DW-1:0] dead_cnt, dead_n;
    logic [11:0]   ramp_duty, ramp_n, duty_n, target;
    logic [12:0]   ramp_sum;
    logic          req_dir, dir_n, tick, boundary, pwm_n;

    always_comb begin
        target  = 12'd0;
        req_dir = 1'b0;
        case (motor_q)
            2'b01:   target = D_FOR;
            2'b11:   target = D_FAST;
            2'b10:   begin target = D_BACK; req_dir = 1'b1; end
            default: target = 12'd0;
        endcase
    end

    assign tick     = (presc == PRESC_MAX);
    assign boundary = (cnt == CNT_MAX);
    assign cnt_n    = boundary ? '0 : cnt + 1'b1;
    assign ramp_sum = {1'b0, ramp_duty} + {1'b0, D_STEP};

    always_comb begin
        state_n = state;
        dir_n   = dir;
        dead_n  = '0;
        case (state)
            IDLE: begin
                if (motor_q != 2'b00) begin
                    state_n = RUN;
                    dir_n   = req_dir;
                end
            end
            RUN: begin
                if (motor_q == 2'b00)   state_n = IDLE;
                else if (req_dir != dir) state_n = DEAD;
            end
            DEAD: begin
                // Command is only looked at on expiry; a stop still aborts at once.
                if (motor_q == 2'b00) begin
                    state_n = IDLE;
                end else if (dead_cnt == DEAD_MAX) begin
                    state_n = RUN;
                    dir_n   = req_dir;
                end else begin
                    dead_n = dead_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ramp_n = ramp_duty;
        if (state_n != RUN || state != RUN)
            ramp_n = 12'd0;
        else if (ramp_duty > target)
            ramp_n = target;
        else if (tick && ramp_duty < target)
            ramp_n = (ramp_sum > {1'b0, target}) ? target : ramp_sum[11:0];

        // Leaving RUN clears duty at once; otherwise duty moves only at the period end.
        if (state_n != RUN) duty_n = 12'd0;
        else if (boundary)  duty_n = ramp_duty;
        else                duty_n = duty;

        pwm_n = (12'(cnt_n) < duty_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            motor_q   <= 2'b00;
            cnt       <= '0;
            presc     <= '0;
            dead_cnt  <= '0;
            ramp_duty <= 12'd0;
            duty      <= 12'd0;
            dir       <= 1'b0;
            in1       <= 1'b0;
            in2       <= 1'b0;
            moving    <= 1'b0;
        end else begin
            state     <= state_n;
            motor_q   <= motor;
            cnt       <= cnt_n;
            presc     <= tick ? '0 : presc + 1'b1;
            dead_cnt  <= dead_n;
            ramp_duty <= ramp_n;
            duty      <= duty_n;
            dir       <= dir_n;
            in1       <= (state_n == RUN) && !dir_n && pwm_n;
            in2       <= (state_n == RUN) &&  dir_n && pwm_n;
            moving    <= (state_n == RUN) && (duty_n != 12'd0);
        end
    end
endmodule

// File: tb/tb_motor_drive.sv
// Directed bench for motor_drive with small parameters; cycle numbers count edges since reset release.
module tb_motor_drive;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  motor;
    logic        in1, in2, dir, moving;
    logic [11:0] duty;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int overlap = 0;
    int c1, c2;

    motor_drive #(
        .PWM_PERIOD(10), .DUTY_FOR(4), .DUTY_FAST(8), .DUTY_BACK(6),
        .RAMP_DIV(3), .RAMP_STEP(2), .DEAD_TIME(20)
    ) dut (
        .clk(clk), .rst(rst), .motor(motor),
        .in1(in1), .in2(in2), .dir(dir), .duty(duty), .moving(moving)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (in1 && in2) overlap++;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after edge k; both sampling and driving happen there.
    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic count_pulses(input int from, input int to);
        c1 = 0;
        c2 = 0;
        for (int k = from; k <= to; k++) begin
            goto(k);
            c1 += int'(in1);
            c2 += int'(in2);
        end
    endtask

    initial begin
        rst   = 1'b1;
        motor = 2'b01;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in1", 16'(in1), 0);
        chk("rst_in2", 16'(in2), 0);
        chk("rst_dir", 16'(dir), 0);
        chk("rst_duty", 16'(duty), 0);
        chk("rst_moving", 16'(moving), 0);
        rst = 1'b0;
        cyc = 0;

        // Start from reset: ticks at 3,6 give ramp 4 before the first wrap at 10.
        goto(9);  chk("start_duty_pre_wrap", 16'(duty), 0);
        chk("start_moving_pre", 16'(moving), 0);
        goto(10); chk("start_duty_wrap", 16'(duty), 4);
        chk("start_moving", 16'(moving), 1);
        count_pulses(10, 19);
        chk("start_in1_width", 16'(c1), 4);
        chk("start_in2_width", 16'(c2), 0);

        // 01 -> 11: ramp 6 at 24, 8 at 27, applied at wrap 30.
        goto(20); motor = 2'b11;
        goto(29); chk("fast_duty_hold", 16'(duty), 4);
        goto(30); chk("fast_duty_wrap", 16'(duty), 8);
        // 11 -> 01: immediate ramp drop, applied at wrap 40, no dead time.
        motor = 2'b01;
        goto(39); chk("slow_duty_hold", 16'(duty), 8);
        goto(40); chk("slow_duty_wrap", 16'(duty), 4);
        chk("slow_dir", 16'(dir), 0);
        chk("slow_in1", 16'(in1), 1);

        // Reversal: 10 sampled at 42, DEAD from 43, RUN backward at 63.
        goto(41); motor = 2'b10;
        goto(42); chk("rev_in1_before", 16'(in1), 1);
        goto(43); chk("rev_in1_cut", 16'(in1), 0);
        chk("rev_duty_cut", 16'(duty), 0);
        goto(62); chk("rev_dir_dead", 16'(dir), 0);
        goto(63); chk("rev_dir_run", 16'(dir), 1);
        goto(70); chk("rev_duty_wrap70", 16'(duty), 4);
        goto(80); chk("rev_duty_wrap80", 16'(duty), 6);
        count_pulses(80, 89);
        chk("rev_in2_width", 16'(c2), 6);
        chk("rev_in1_width", 16'(c1), 0);

        // Toggling during DEAD (92..111) must not shorten it; 10 at expiry resumes backward.
        goto(90);  motor = 2'b01;
        goto(95);  motor = 2'b10;
        goto(100); motor = 2'b01;
        goto(105); motor = 2'b10;
        goto(110); chk("tog_duty_dead", 16'(duty), 0);
        goto(111); chk("tog_moving_dead", 16'(moving), 0);
        // Tick and wrap coincide at 120: wrap takes pre-tick ramp 4.
        goto(120); chk("tog_duty_wrap120", 16'(duty), 4);
        chk("tog_in2", 16'(in2), 1);
        goto(130); chk("tog_duty_wrap130", 16'(duty), 6);

        // Stop during DEAD: IDLE at 137, so 11 restarts forward at 139 without dead time.
        motor = 2'b01;
        goto(135); motor = 2'b00;
        goto(137); motor = 2'b11;
        goto(139); chk("abort_dir", 16'(dir), 0);
        goto(150); chk("abort_duty_wrap150", 16'(duty), 6);
        goto(160); chk("abort_duty_wrap160", 16'(duty), 8);

        // Stop mid-period: counter 3 at 163, in1 drops at 164.
        goto(162); motor = 2'b00;
        goto(163); chk("stop_in1_before", 16'(in1), 1);
        goto(164); chk("stop_in1_cut", 16'(in1), 0);
        chk("stop_duty", 16'(duty), 0);
        chk("stop_moving", 16'(moving), 0);

        // Restart: duty 2 at wrap 170, 4 at 180; then reset mid-run.
        motor = 2'b01;
        goto(170); chk("re_duty_wrap170", 16'(duty), 2);
        goto(180); chk("re_duty_wrap180", 16'(duty), 4);
        goto(181); rst = 1'b1;
        goto(182);
        chk("mrst_in1", 16'(in1), 0);
        chk("mrst_duty", 16'(duty), 0);
        chk("mrst_moving", 16'(moving), 0);
        chk("mrst_dir", 16'(dir), 0);
        rst = 1'b0;
        cyc = 0;
        goto(9);  chk("post_duty_pre_wrap", 16'(duty), 0);
        goto(10); chk("post_duty_wrap", 16'(duty), 4);
        count_pulses(10, 19);
        chk("post_in1_width", 16'(c1), 4);

        chk("no_overlap", 16'(overlap), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
